// File: rtl/fetch_sequencer_if.sv
// Bus bundle between fetch_sequencer, programMem and the datapath.
//   master : the fetch sequencer (drives address, IR, status)
//   slave  : programMem / datapath side (drives instruction word, exec handshake)
interface fetch_sequencer_if #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int COUNT_WIDTH   = 16
);
  logic [DATAWIDTH_BUS-1:0] BusDirecciones;
  logic [DATAWIDTH_BUS-1:0] BusDatos;
  logic                     FetchSeq_Start_In;
  logic [DATAWIDTH_BUS-1:0] FetchSeq_IR_Out;
  logic [DATAWIDTH_BUS-1:0] FetchSeq_IRPC_Out;
  logic                     FetchSeq_IRValid_Out;
  logic                     FetchSeq_ExecDone_In;
  logic                     FetchSeq_BranchTaken_In;
  logic [DATAWIDTH_BUS-1:0] FetchSeq_BranchTarget_In;
  logic                     FetchSeq_Annul_In;
  logic                     FetchSeq_Halted_Out;
  logic [COUNT_WIDTH-1:0]   FetchSeq_InstrCount_Out;

  modport master (
    output BusDirecciones, FetchSeq_IR_Out, FetchSeq_IRPC_Out,
           FetchSeq_IRValid_Out, FetchSeq_Halted_Out, FetchSeq_InstrCount_Out,
    input  BusDatos, FetchSeq_Start_In, FetchSeq_ExecDone_In,
           FetchSeq_BranchTaken_In, FetchSeq_BranchTarget_In, FetchSeq_Annul_In
  );

  modport slave (
    input  BusDirecciones, FetchSeq_IR_Out, FetchSeq_IRPC_Out,
           FetchSeq_IRValid_Out, FetchSeq_Halted_Out, FetchSeq_InstrCount_Out,
    output BusDatos, FetchSeq_Start_In, FetchSeq_ExecDone_In,
           FetchSeq_BranchTaken_In, FetchSeq_BranchTarget_In, FetchSeq_Annul_In
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for uDataPath.
// Keeps PC/nPC with delayed-branch semantics, presents PC on BusDirecciones,
// captures the combinational ROM word into IR and hands it to the datapath
// with an IRValid/ExecDone handshake. Fetching an all-zero word halts.
// Ports:
//   CLOCK_50    : system clock, rising edge
//   RESET_InLow : asynchronous active-low reset
//   fetchBus    : master side of fetch_sequencer_if (address, IR, handshake,
//                 branch resolution inputs, halted flag, retired count)
module fetch_sequencer #(
  parameter int                       DATAWIDTH_BUS = 32,
  parameter logic [DATAWIDTH_BUS-1:0] RESET_PC      = 32'h0000_0800,
  parameter int                       COUNT_WIDTH   = 16
) (
  input  logic               CLOCK_50,
  input  logic               RESET_InLow,
  fetch_sequencer_if.master  fetchBus
);

  localparam logic [DATAWIDTH_BUS-1:0] ONE       = DATAWIDTH_BUS'(1);
  localparam logic [DATAWIDTH_BUS-1:0] TWO       = DATAWIDTH_BUS'(2);
  localparam logic [DATAWIDTH_BUS-1:0] RESET_NPC = RESET_PC + ONE;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t                   state, stateNext;
  logic [DATAWIDTH_BUS-1:0] pc, pcNext;
  logic [DATAWIDTH_BUS-1:0] nPc, nPcNext;
  logic [DATAWIDTH_BUS-1:0] ir, irNext;
  logic [DATAWIDTH_BUS-1:0] irPc, irPcNext;
  logic                     irValid, irValidNext;
  logic                     halted, haltedNext;
  logic [COUNT_WIDTH-1:0]   instrCount, instrCountNext;

  // Everything architectural lives in one register bank; the address bus is
  // taken straight from pc so there is no input-to-address combinational path.
  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      nPc        <= RESET_NPC;
      ir         <= '0;
      irPc       <= '0;
      irValid    <= 1'b0;
      halted     <= 1'b0;
      instrCount <= '0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      nPc        <= nPcNext;
      ir         <= irNext;
      irPc       <= irPcNext;
      irValid    <= irValidNext;
      halted     <= haltedNext;
      instrCount <= instrCountNext;
    end
  end

  always_comb begin
    stateNext      = state;
    pcNext         = pc;
    nPcNext        = nPc;
    irNext         = ir;
    irPcNext       = irPc;
    irValidNext    = irValid;
    haltedNext     = halted;
    instrCountNext = instrCount;

    case (state)
      IDLE: begin
        if (fetchBus.FetchSeq_Start_In) stateNext = FETCH;
      end

      // ROM is combinational: the word for pc is already on BusDatos.
      FETCH: begin
        irNext   = fetchBus.BusDatos;
        irPcNext = pc;
        if (fetchBus.BusDatos == '0) begin
          stateNext  = HALT;
          haltedNext = 1'b1;
        end else begin
          stateNext   = ISSUE;
          irValidNext = 1'b1;
        end
      end

      ISSUE: begin
        if (fetchBus.FetchSeq_ExecDone_In) begin
          stateNext   = FETCH;
          irValidNext = 1'b0;
          if (instrCount != '1) instrCountNext = instrCount + COUNT_WIDTH'(1);
          // Delayed branch: without annul the slot at nPc still runs before
          // the target; annul skips that slot.
          case ({fetchBus.FetchSeq_BranchTaken_In, fetchBus.FetchSeq_Annul_In})
            2'b10: begin
              pcNext  = nPc;
              nPcNext = fetchBus.FetchSeq_BranchTarget_In;
            end
            2'b11: begin
              pcNext  = fetchBus.FetchSeq_BranchTarget_In;
              nPcNext = fetchBus.FetchSeq_BranchTarget_In + ONE;
            end
            2'b01: begin
              pcNext  = nPc + ONE;
              nPcNext = nPc + TWO;
            end
            default: begin
              pcNext  = nPc;
              nPcNext = nPc + ONE;
            end
          endcase
        end
      end

      HALT: begin
        // absorbing; only reset leaves
      end

      default: stateNext = IDLE;
    endcase
  end

  assign fetchBus.BusDirecciones          = pc;
  assign fetchBus.FetchSeq_IR_Out         = ir;
  assign fetchBus.FetchSeq_IRPC_Out       = irPc;
  assign fetchBus.FetchSeq_IRValid_Out    = irValid;
  assign fetchBus.FetchSeq_Halted_Out     = halted;
  assign fetchBus.FetchSeq_InstrCount_Out = instrCount;

endmodule
